// File: rtl/fb_pipereg.sv
// Pipeline stage register: valid/ready payload stage with flush, optional 2-entry skid and stall counter.
// Latency: 1 cycle from in_fire to out_valid. Backpressure: SKID=1 gives a registered in_ready, SKID=0 a combinational one.
module fb_pipereg #(
    parameter int DW    = 96,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   main_q;
    logic [DW-1:0]   skid_q;
    logic            in_ready_q;
    logic            in_fire;
    logic            out_fire;
    logic            load_in;
    logic            load_skid;
    logic            load_from_skid;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    // The skid variant only ever looks at the flop, keeping the upstream ready path register-timed.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    load_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    load_in = 1'b1;
                end else if (in_fire) begin
                    if (SKID != 0) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else begin
                        load_in = 1'b1;
                    end
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_d        = ST_FULL;
                    load_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            stall_cnt  <= '0;
        end else if (flush) begin
            // Bubble insertion: held entries and any same-cycle input are dropped, the counter survives.
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
            if (load_in) begin
                main_q <= in_data;
            end else if (load_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_pipereg.sv
// Randomised and directed bench for three fb_pipereg variants against a capacity-limited queue model.
module tb_fb_pipereg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [95:0] in_data;
    logic        out_ready;

    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [95:0] od_a, od_b, od_c;
    logic [15:0] sc_a;
    logic [3:0]  sc_b, sc_c;
    logic [95:0] od [3];
    logic [15:0] sc [3];

    int errors = 0;
    int checks = 0;

    // Per-variant model: capacity (2 with skid, 1 without), held entries in arrival order.
    int          cap  [3] = '{2, 1, 2};
    int          cmax [3] = '{65535, 15, 15};
    logic [95:0] ent  [3][2];
    int          n    [3] = '{0, 0, 0};
    logic [95:0] last [3];
    int          cnt  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    fb_pipereg #(.DW(96), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od_a), .stall_cnt(sc_a));
    fb_pipereg #(.DW(96), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_b), .stall_cnt(sc_b));
    fb_pipereg #(.DW(96), .SKID(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od_c), .stall_cnt(sc_c));

    assign od[0] = od_a;
    assign od[1] = od_b;
    assign od[2] = od_c;
    assign sc[0] = sc_a;
    assign sc[1] = 16'(sc_b);
    assign sc[2] = 16'(sc_c);

    function automatic logic exp_ready(int d);
        if (cap[d] == 2) return (n[d] < 2);
        return (n[d] == 0) || out_ready;
    endfunction

    task automatic chk(input string nm, input int d, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, d, $time, got, exp);
        end
    endtask

    // Model update at the active edge: the inputs are stable here because they change #1 later.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                n[d] = 0; last[d] = '0; cnt[d] = 0;
            end else if (flush) begin
                n[d] = 0; last[d] = '0;
            end else begin
                logic rdy, ofire, ifire;
                rdy   = exp_ready(d);
                ofire = (n[d] > 0) && out_ready;
                ifire = in_valid && rdy;
                if (n[d] > 0 && !out_ready && cnt[d] < cmax[d]) cnt[d]++;
                if (ofire) begin
                    ent[d][0] = ent[d][1];
                    n[d]--;
                end
                if (ifire) begin
                    ent[d][n[d]] = in_data;
                    n[d]++;
                end
                if (n[d] > 0) last[d] = ent[d][0];
            end
        end
    end

    // Monitor: compares whatever each DUT presents against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk("in_ready", d, 96'(ir[d]), 96'(exp_ready(d)));
            chk("out_valid", d, 96'(ov[d]), 96'(n[d] > 0));
            if (n[d] > 0) chk("out_data", d, od[d], ent[d][0]);
            else          chk("idle_data", d, od[d], last[d]);
            chk("stall_cnt", d, 96'(sc[d]), 96'(cnt[d]));
        end
    end

    task automatic cyc(input logic v, input logic [95:0] dat, input logic r, input logic f);
        in_valid  = v;
        in_data   = dat;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [95:0] va, vb, vc;
        rst = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        rst = 1'b0;

        // Streaming with the downstream always ready.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 96'(i), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Backpressure then release.
        va = rnd96(); vb = rnd96(); vc = rnd96();
        cyc(1'b1, va, 1'b0, 1'b0);
        cyc(1'b1, vb, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush while full, with a new entry offered in the same cycle.
        cyc(1'b1, va, 1'b0, 1'b0);
        cyc(1'b1, vb, 1'b0, 1'b0);
        cyc(1'b1, vc, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Back-to-back transfers.
        for (int i = 0; i < 10; i++) cyc(1'b1, 96'(100 + i), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Long stall to saturate the narrow counters, then reset mid-stall.
        cyc(1'b1, rnd96(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Random traffic; payload is junk whenever it is not offered.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, rnd96(), ($urandom % 3) != 0, ($urandom % 32) == 0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_pipereg.md
Name: fb_pipereg

Overview:
- Parametrised pipeline stage register for the Firebird pipeline. It is the generalised replacement for fixed per-stage latch registers such as IF/ID, ID/EX and EX/MEM.
- It carries an arbitrary-width payload using a valid/ready handshake, with flush (bubble insertion on misprediction) and backpressure (data-hazard lock).
- An optional 2-entry skid buffer makes the upstream ready signal fully registered, which breaks the combinational ready path.
- A built-in saturating stall counter supports performance analysis.

Parameters:
- DW, 96: payload width in bits (default = pc, pc+1 and inst, 32 bits each).
- SKID, 1: 1 selects the skid-buffer variant with registered in_ready; 0 selects the single-entry variant with combinational in_ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries; the stage becomes an empty bubble.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  DW  payload from upstream stage.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts out_data this cycle (0 = lock/stall).
- out_data  out  DW  payload presented to downstream stage.
- stall_cnt  out  CNT_W  number of cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset values: state EMPTY, out_valid=0, out_data=0, skid payload=0, stall_cnt=0, in_ready=1 (SKID=1).
- Priority order: rst > flush > normal operation.
- Flush behaviour:
  - state goes to EMPTY; main and skid payloads cleared to 0.
  - stall_cnt is kept.
  - An in_fire in the same cycle is discarded. Upstream treats it as consumed.
- Latency: one cycle from in_fire to out_valid=1 with that data.
- out_data equals the main register. It is 0 whenever the stage is EMPTY via rst/flush. After a drain, out_data keeps its stale value but out_valid=0.
- SKID=1 state machine:
  - EMPTY (in_ready=1, out_valid=0):
    - in_fire -> FULL, main<=in_data.
  - FULL (in_ready=1, out_valid=1):
    - in_fire & out_fire -> FULL, main<=in_data.
    - in_fire & !out_fire -> SKID, skid<=in_data, main held.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - SKID (in_ready=0, out_valid=1):
    - out_fire -> FULL, main<=skid.
    - otherwise hold. in_valid is ignored.
  - in_ready is a flop: in_ready = (next_state != SKID).
- SKID=0 variant:
  - States are EMPTY and FULL only.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main and leaves/stays in FULL.
  - out_fire without in_fire goes to EMPTY.
- Ordering and integrity:
  - Entries leave in arrival order; no entry is duplicated or dropped except by flush.
  - out_data/out_valid are stable while out_valid=1 and out_ready=0.
- stall_cnt: increments by 1 on each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1 (no wrap); cleared only by rst.
- in_data is sampled only on in_fire; X on in_data when in_valid=0 must not propagate.

Test Plan:
- Reset then stream: in_data=1,2,3 on consecutive cycles with out_ready=1 -> out_data=1,2,3 one cycle later each, in_ready always 1, stall_cnt=0.
- Backpressure (SKID=1): out_ready=0 while sending A then B -> out_data=A; in_ready drops to 0 the cycle after B is accepted. Release out_ready -> A then B out in order; in_ready returns to 1 one cycle after A leaves; stall_cnt equals the number of blocked cycles.
- Flush in SKID state holding A,B with in_valid=1,C -> next cycle out_valid=0, out_data=0, in_ready=1; C never appears.
- Simultaneous in_fire and out_fire in FULL for 10 cycles -> one transfer per cycle, state stays FULL, no bubbles.
- Saturation with CNT_W=4: hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt stops at 15. Then assert rst mid-stall -> all outputs at reset values the next cycle.
- SKID=0: out_ready=0 with entry held -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> in_ready=1 in the same cycle, with pass-through replacement.
